// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the runtime-configurable convolution loop controller.
package conv_ctrl_pkg;

    localparam int CFG_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] width;
        logic [CFG_W-1:0] height;
        logic [CFG_W-1:0] in_ch;
        logic [CFG_W-1:0] out_ch;
        logic [CFG_W-1:0] kernel;
    } conv_cfg_t;

    localparam conv_cfg_t CFG_ONES = '{
        width:  CFG_W'(1),
        height: CFG_W'(1),
        in_ch:  CFG_W'(1),
        out_ch: CFG_W'(1),
        kernel: CFG_W'(1)
    };

    // A zero-sized dimension makes no sense for a loop nest, so it runs once.
    function automatic logic [CFG_W-1:0] clamp1(input logic [CFG_W-1:0] v);
        return (v == '0) ? CFG_W'(1) : v;
    endfunction

endpackage

// File: rtl/conv_loop_controller_loop_counter.sv
// One level of the loop nest: counts 0..max on en and wraps, flagging its last value.
module loop_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] max,
    output logic             last,
    output logic [CNT_W-1:0] q
);

    assign last = (q == max);

    always_ff @(posedge clk) begin
        if (rst_in || clr) begin
            q <= '0;
        end else if (en) begin
            q <= last ? '0 : q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/conv_loop_controller.sv
// Sequences the x -> y -> ch_in -> ch_out group -> k_v -> k_h loop nest over a
// runtime-configured feature map, driving the datapad, MAC array and partial-sum memory.
module conv_loop_controller
    import conv_ctrl_pkg::*;
#(
    parameter int CNT_W              = CFG_W,
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int OUT_LANES          = 4
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic [CNT_W-1:0]              cfg_width,
    input  logic [CNT_W-1:0]              cfg_height,
    input  logic [CNT_W-1:0]              cfg_in_ch,
    input  logic [CNT_W-1:0]              cfg_out_ch,
    input  logic [CNT_W-1:0]              cfg_kernel,
    output logic                          running,
    output logic                          done,
    output logic                          cfg_err,
    input  logic                          a_valid,
    input  logic                          b_valid,
    output logic                          a_ready,
    output logic                          b_ready,
    output logic                          write_a,
    output logic                          write_b,
    output logic                          mac_valid,
    output logic                          mac_accumulate_internal,
    output logic                          mac_accumulate_with_0,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [31:0]                   output_x,
    output logic [31:0]                   output_y,
    output logic [31:0]                   output_ch
);

    ctrl_state_t state;
    conv_cfg_t   cfg_q;
    conv_cfg_t   cfg_in;
    logic        cfg_bad;
    logic        start_ok;
    logic        in_run;
    logic        stall;
    logic        fire;
    logic        first_tap;
    logic        load_beat;
    logic        psum_done;
    logic        last_overall;

    logic [CNT_W-1:0] max_x, max_y, max_ci, max_grp, max_k;
    logic [CNT_W-1:0] x_q, y_q, ci_q, grp_q, kv_q, kh_q;
    logic             last_x, last_y, last_ci, last_grp, last_kv, last_kh;
    logic             en_kv, en_grp, en_ci, en_y, en_x;

    function automatic logic [31:0] group_count(input logic [CFG_W-1:0] out_ch);
        return (32'(out_ch) + 32'(OUT_LANES) - 32'd1) / 32'(OUT_LANES);
    endfunction

    always_comb begin
        cfg_in.width  = clamp1(CFG_W'(cfg_width));
        cfg_in.height = clamp1(CFG_W'(cfg_height));
        cfg_in.in_ch  = clamp1(CFG_W'(cfg_in_ch));
        cfg_in.out_ch = clamp1(CFG_W'(cfg_out_ch));
        cfg_in.kernel = clamp1(CFG_W'(cfg_kernel));
    end

    // Each group owns one partial-sum row, so more groups than rows cannot run.
    assign cfg_bad  = 64'(group_count(cfg_in.out_ch)) > (64'd1 << LOG2_OF_MEM_HEIGHT);
    assign start_ok = (state == IDLE) && start && !cfg_bad;

    assign max_x   = CNT_W'(cfg_q.width  - CFG_W'(1));
    assign max_y   = CNT_W'(cfg_q.height - CFG_W'(1));
    assign max_ci  = CNT_W'(cfg_q.in_ch  - CFG_W'(1));
    assign max_k   = CNT_W'(cfg_q.kernel - CFG_W'(1));
    assign max_grp = CNT_W'(group_count(cfg_q.out_ch) - 32'd1);

    assign in_run    = (state == RUN);
    assign stall     = output_valid && !output_ready;
    assign a_ready   = in_run && !stall;
    assign b_ready   = a_ready;
    assign fire      = a_ready && a_valid && b_valid;
    assign write_a   = fire;
    assign write_b   = fire;
    assign mac_valid = fire;

    assign first_tap               = (kv_q == '0) && (kh_q == '0);
    assign mac_accumulate_internal = in_run && !first_tap;
    assign mac_accumulate_with_0   = in_run && first_tap && (ci_q == '0);
    assign mem_re                  = fire && first_tap;
    assign mem_read_addr           = LOG2_OF_MEM_HEIGHT'(grp_q);

    assign en_kv  = fire   && last_kh;
    assign en_grp = en_kv  && last_kv;
    assign en_ci  = en_grp && last_grp;
    assign en_y   = en_ci  && last_ci;
    assign en_x   = en_y   && last_y;

    assign psum_done    = en_grp;
    assign load_beat    = psum_done && last_ci;
    assign last_overall = en_x && last_x;

    loop_counter #(.CNT_W(CNT_W)) u_kh (
        .clk(clk), .rst_in(rst_in), .en(fire), .clr(start_ok),
        .max(max_k), .last(last_kh), .q(kh_q)
    );

    loop_counter #(.CNT_W(CNT_W)) u_kv (
        .clk(clk), .rst_in(rst_in), .en(en_kv), .clr(start_ok),
        .max(max_k), .last(last_kv), .q(kv_q)
    );

    loop_counter #(.CNT_W(CNT_W)) u_grp (
        .clk(clk), .rst_in(rst_in), .en(en_grp), .clr(start_ok),
        .max(max_grp), .last(last_grp), .q(grp_q)
    );

    loop_counter #(.CNT_W(CNT_W)) u_ci (
        .clk(clk), .rst_in(rst_in), .en(en_ci), .clr(start_ok),
        .max(max_ci), .last(last_ci), .q(ci_q)
    );

    loop_counter #(.CNT_W(CNT_W)) u_y (
        .clk(clk), .rst_in(rst_in), .en(en_y), .clr(start_ok),
        .max(max_y), .last(last_y), .q(y_q)
    );

    loop_counter #(.CNT_W(CNT_W)) u_x (
        .clk(clk), .rst_in(rst_in), .en(en_x), .clr(start_ok),
        .max(max_x), .last(last_x), .q(x_q)
    );

    // A beat can only load while the previous one is absent or being accepted,
    // because a stalled output blocks fire.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state          <= IDLE;
            cfg_q          <= CFG_ONES;
            running        <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            output_valid   <= 1'b0;
            output_x       <= '0;
            output_y       <= '0;
            output_ch      <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            mem_we  <= psum_done;
            if (psum_done) begin
                mem_write_addr <= LOG2_OF_MEM_HEIGHT'(grp_q);
            end

            if (load_beat) begin
                output_valid <= 1'b1;
                output_x     <= 32'(x_q);
                output_y     <= 32'(y_q);
                output_ch    <= 32'(grp_q) * 32'(OUT_LANES);
            end else if (output_valid && output_ready) begin
                output_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_q   <= cfg_in;
                            running <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_overall) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!output_valid || output_ready) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_loop_controller.sv
// Randomised scoreboard bench for conv_loop_controller: a loop-nest reference model
// predicts every fire, partial-sum write and output beat; a negedge monitor compares.
module tb_conv_loop_controller;

    localparam int CNT_W  = 16;
    localparam int LOG2_H = 3;
    localparam int LANES  = 4;

    logic clk = 1'b0;
    logic rst_in, start;
    logic [CNT_W-1:0] cfg_width, cfg_height, cfg_in_ch, cfg_out_ch, cfg_kernel;
    logic running, done, cfg_err;
    logic a_valid, b_valid, a_ready, b_ready, write_a, write_b;
    logic mac_valid, mac_accumulate_internal, mac_accumulate_with_0;
    logic mem_re, mem_we;
    logic [LOG2_H-1:0] mem_read_addr, mem_write_addr;
    logic output_valid, output_ready;
    logic [31:0] output_x, output_y, output_ch;

    always #5 clk = ~clk;

    conv_loop_controller #(
        .CNT_W(CNT_W), .LOG2_OF_MEM_HEIGHT(LOG2_H), .OUT_LANES(LANES)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_in_ch(cfg_in_ch),
        .cfg_out_ch(cfg_out_ch), .cfg_kernel(cfg_kernel),
        .running(running), .done(done), .cfg_err(cfg_err),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
        .mac_accumulate_internal(mac_accumulate_internal),
        .mac_accumulate_with_0(mac_accumulate_with_0),
        .mem_re(mem_re), .mem_read_addr(mem_read_addr),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
    );

    typedef struct {
        bit with0;
        bit internal;
        bit re;
        bit we;
        bit beat;
        int grp;
    } fire_t;

    typedef struct {
        int x;
        int y;
        int ch;
    } beat_t;

    fire_t fire_q[$];
    beat_t beat_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en = 0, in_run = 0, in_drain = 0, pend = 0, we_due = 0, done_due = 0;
    bit run_complete = 0, tog = 0;
    int we_addr = 0, fires_seen = 0, beats_seen = 0, stall_cnt = 0, done_count = 0, bp_cnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    function automatic int clampv(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference: walk the loop nest with plain for loops, recording what each fire must do.
    task automatic buildModel(input int w, input int h, input int ci, input int co, input int k);
        int gw = clampv(w), gh = clampv(h), gci = clampv(ci), gk = clampv(k);
        int groups = (clampv(co) + LANES - 1) / LANES;
        for (int x = 0; x < gw; x++)
            for (int y = 0; y < gh; y++)
                for (int c = 0; c < gci; c++)
                    for (int g = 0; g < groups; g++)
                        for (int v = 0; v < gk; v++)
                            for (int hh = 0; hh < gk; hh++) begin
                                fire_t e;
                                e.with0    = (c == 0) && (v == 0) && (hh == 0);
                                e.internal = !((v == 0) && (hh == 0));
                                e.re       = (v == 0) && (hh == 0);
                                e.we       = (v == gk - 1) && (hh == gk - 1);
                                e.beat     = e.we && (c == gci - 1);
                                e.grp      = g;
                                fire_q.push_back(e);
                                if (e.beat) beat_q.push_back('{x: x, y: y, ch: g * LANES});
                            end
    endtask

    task automatic resetModel();
        fire_q.delete();
        beat_q.delete();
        in_run = 0; in_drain = 0; pend = 0; we_due = 0; done_due = 0;
    endtask

    always @(negedge clk) begin : monitor
        fire_t e;
        bit exp_ready, exp_fire, nx_pend, nx_we, nx_done;
        if (done) done_count++;
        if (mon_en) begin
            checkOutput("done", done, done_due);
            if (done_due) run_complete = 1;
            checkOutput("running", running, in_run || in_drain);
            checkOutput("output_valid", output_valid, pend);
            if (pend) begin
                if (beat_q.size() == 0) failNow("unexpected_beat");
                else begin
                    checkOutput("output_x", output_x, beat_q[0].x);
                    checkOutput("output_y", output_y, beat_q[0].y);
                    checkOutput("output_ch", output_ch, beat_q[0].ch);
                end
                if (!output_ready) stall_cnt++;
            end
            checkOutput("mem_we", mem_we, we_due);
            if (we_due) checkOutput("mem_write_addr", mem_write_addr, we_addr);

            exp_ready = in_run && !(pend && !output_ready);
            exp_fire  = exp_ready && a_valid && b_valid;
            checkOutput("a_ready", a_ready, exp_ready);
            checkOutput("b_ready", b_ready, exp_ready);
            checkOutput("mac_valid", mac_valid, exp_fire);
            checkOutput("write_ab", {write_a, write_b}, {exp_fire, exp_fire});

            nx_pend = pend && !output_ready;
            nx_we   = 0;
            nx_done = 0;
            if (pend && output_ready && beat_q.size() != 0) begin
                void'(beat_q.pop_front());
                beats_seen++;
            end
            if (in_drain && (!pend || output_ready)) begin
                in_drain = 0;
                nx_done  = 1;
            end
            if (exp_fire) begin
                if (fire_q.size() == 0) failNow("unexpected_fire");
                else begin
                    e = fire_q.pop_front();
                    fires_seen++;
                    checkOutput("acc_with_0", mac_accumulate_with_0, e.with0);
                    checkOutput("acc_internal", mac_accumulate_internal, e.internal);
                    checkOutput("mem_re", mem_re, e.re);
                    if (e.re) checkOutput("mem_read_addr", mem_read_addr, e.grp);
                    nx_we   = e.we;
                    we_addr = e.grp;
                    if (e.beat) nx_pend = 1;
                    if (fire_q.size() == 0) begin
                        in_run   = 0;
                        in_drain = 1;
                    end
                end
            end else begin
                checkOutput("mem_re_idle", mem_re, 1'b0);
            end
            pend     = nx_pend;
            we_due   = nx_we;
            done_due = nx_done;
        end
    end

    // vmode: 0 both valid, 1 b toggles, 2 random. rmode: 0 ready, 1 hold 5 after first beat, 2 random.
    task automatic driveInputs(input int vmode, input int rmode);
        case (vmode)
            0: begin a_valid = 1; b_valid = 1; end
            1: begin a_valid = 1; b_valid = tog; tog = !tog; end
            default: begin
                a_valid = ($urandom_range(0, 99) < 70);
                b_valid = ($urandom_range(0, 99) < 70);
            end
        endcase
        case (rmode)
            0: output_ready = 1;
            1: begin
                if (output_valid && bp_cnt < 5) begin
                    output_ready = 0;
                    bp_cnt++;
                end else output_ready = 1;
            end
            default: output_ready = ($urandom_range(0, 99) < 60);
        endcase
    endtask

    task automatic applyStimulus(input int w, input int h, input int ci, input int co, input int k,
                                 input int vmode, input int rmode);
        int n_fires;
        buildModel(w, h, ci, co, k);
        n_fires = fire_q.size();
        fires_seen = 0; beats_seen = 0; stall_cnt = 0; bp_cnt = 0; tog = 0; run_complete = 0;
        @(posedge clk); #1;
        cfg_width = CNT_W'(w); cfg_height = CNT_W'(h); cfg_in_ch = CNT_W'(ci);
        cfg_out_ch = CNT_W'(co); cfg_kernel = CNT_W'(k);
        start = 1; a_valid = 0; b_valid = 0; output_ready = 1;
        @(posedge clk); #1;
        start = 0;
        in_run = 1;
        cfg_width = CNT_W'($urandom); cfg_out_ch = CNT_W'($urandom);
        driveInputs(vmode, rmode);
        for (int c = 0; c < 6000 && !run_complete; c++) begin
            @(posedge clk); #1;
            driveInputs(vmode, rmode);
        end
        if (!run_complete) failNow("run_timeout");
        checkOutput("fire_count", fires_seen, n_fires);
        checkOutput("fires_left", fire_q.size(), 0);
        checkOutput("beats_left", beat_q.size(), 0);
        a_valid = 0; b_valid = 0; output_ready = 1;
    endtask

    initial begin
        int dc;
        rst_in = 1; start = 0; a_valid = 0; b_valid = 0; output_ready = 1;
        cfg_width = '0; cfg_height = '0; cfg_in_ch = '0; cfg_out_ch = '0; cfg_kernel = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_running", running, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_output_valid", output_valid, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_acc_with_0", mac_accumulate_with_0, 0);
        checkOutput("rst_output_x", output_x, 0);
        rst_in = 0;
        @(posedge clk); #1;
        checkOutput("idle_running", running, 0);
        mon_en = 1;

        applyStimulus(2, 2, 1, 4, 1, 0, 0);
        checkOutput("minimal_fires", fires_seen, 4);
        checkOutput("minimal_beats", beats_seen, 4);

        applyStimulus(1, 1, 2, 8, 3, 0, 0);
        checkOutput("psum_fires", fires_seen, 36);
        checkOutput("psum_beats", beats_seen, 2);

        applyStimulus(2, 2, 1, 4, 1, 0, 1);
        checkOutput("bp_stall_cycles", stall_cnt, 5);

        applyStimulus(2, 1, 1, 4, 2, 1, 0);

        @(posedge clk); #1;
        cfg_width = 1; cfg_height = 1; cfg_in_ch = 1; cfg_out_ch = 33; cfg_kernel = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        checkOutput("cfg_err_pulse", cfg_err, 1);
        checkOutput("cfg_err_running", running, 0);
        @(posedge clk); #1;
        checkOutput("cfg_err_clear", cfg_err, 0);
        checkOutput("cfg_err_idle", running, 0);

        applyStimulus(1, 1, 1, 32, 1, 0, 0);
        checkOutput("max_groups_beats", beats_seen, 8);

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_cfg_fires", fires_seen, 1);
        checkOutput("zero_cfg_beats", beats_seen, 1);

        for (int r = 0; r < 6; r++)
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom_range(0, 12), $urandom_range(0, 3), 2, 2);

        mon_en = 0;
        resetModel();
        @(posedge clk); #1;
        cfg_width = 2; cfg_height = 2; cfg_in_ch = 1; cfg_out_ch = 4; cfg_kernel = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0; a_valid = 1; b_valid = 1; output_ready = 0;
        for (int c = 0; c < 20 && !output_valid; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("midrun_pending", output_valid, 1);
        dc = done_count;
        rst_in = 1;
        @(posedge clk); #1;
        rst_in = 0; a_valid = 0; b_valid = 0; output_ready = 1;
        checkOutput("midrun_output_valid", output_valid, 0);
        checkOutput("midrun_running", running, 0);
        checkOutput("midrun_a_ready", a_ready, 0);
        checkOutput("midrun_mem_we", mem_we, 0);
        checkOutput("midrun_output_x", output_x, 0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrun_no_done", done_count, dc);
        checkOutput("midrun_idle", running, 0);
        mon_en = 1;

        applyStimulus(2, 2, 1, 4, 1, 0, 0);
        checkOutput("recover_beats", beats_seen, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
